// File: rtl/ntt_result_collector_if.sv
// Output coefficient stream of ntt_result_collector: valid/ready with natural-order index and last flag.
interface ntt_result_collector_if #(
    parameter int unsigned COEF_W = 12,
    parameter int unsigned IDX_W  = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [COEF_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;

    modport master (output out_valid, out_data, out_index, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/ntt_result_collector.sv
// Captures interleaved NTT output bursts, reduces each word once mod q, stores in natural order, then drains.
// Optional RESULT_RANGE_CHECK_EN builds the sticky range_err detector; otherwise range_err is tied low.
module ntt_result_collector #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned COEF_W   = 12,
    parameter int unsigned MAX_N    = 256,
    parameter int unsigned PE_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done,
    input  logic [DATA_W-1:0]      dout0,
    input  logic [COEF_W-1:0]      q,
    input  logic [11:0]            ring_size,
    ntt_result_collector_if.master out_if,
    output logic                   busy,
    output logic                   range_err
);
    localparam int unsigned IDX_W = $clog2(MAX_N);
    localparam logic [IDX_W:0]    PTR_ONE  = 1;
    localparam logic [PE_DEPTH:0] BEAT_ONE = 1;

    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, GAP, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              done_d;
    logic              done_rise;
    logic [COEF_W-1:0] q_r;
    logic [IDX_W:0]    ring_r;
    logic [IDX_W:0]    m;
    logic [IDX_W:0]    rd_ptr;
    logic [PE_DEPTH:0] beat;
    logic              burst_end;
    logic [COEF_W:0]   c;
    logic [COEF_W-1:0] c_red;
    logic [IDX_W:0]    wr_addr_full;
    logic              xfer;
    logic              fetch;
    logic              unused_bits;

    logic [COEF_W-1:0] buffer [MAX_N];

    assign unused_bits = ^{dout0[DATA_W-1:COEF_W+1], ring_size};

    assign done_rise = done & ~done_d;
    assign burst_end = (beat == '1);
    assign busy      = (state_q != IDLE);
    assign xfer      = out_if.out_valid & out_if.out_ready;
    // Refill the output register whenever it is empty or being emptied this cycle.
    assign fetch     = (state_q == DRAIN) && (rd_ptr != ring_r) && (!out_if.out_valid || out_if.out_ready);

    always_comb begin
        c     = dout0[COEF_W:0];
        c_red = c[COEF_W-1:0];
        if (c >= {1'b0, q_r}) begin
            c_red = COEF_W'(c - {1'b0, q_r});
        end
        // Even words fill the lower half, odd words the upper half.
        wr_addr_full = m >> 1;
        if (m[0]) begin
            wr_addr_full = (m >> 1) + (ring_r >> 1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (done_rise) state_d = ARM;
            ARM:     state_d = CAPTURE;
            CAPTURE: if (burst_end) state_d = GAP;
            GAP:     state_d = (m == ring_r) ? DRAIN : CAPTURE;
            DRAIN:   if (xfer && out_if.out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            done_d           <= 1'b0;
            q_r              <= '0;
            ring_r           <= '0;
            m                <= '0;
            beat             <= '0;
            rd_ptr           <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_index <= '0;
            out_if.out_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_d  <= done;
            if (state_q == IDLE && done_rise) begin
                q_r    <= q;
                ring_r <= ring_size[IDX_W:0];
                m      <= '0;
                beat   <= '0;
                rd_ptr <= '0;
            end
            if (state_q == CAPTURE) begin
                m    <= m + PTR_ONE;
                beat <= burst_end ? '0 : beat + BEAT_ONE;
            end
            if (fetch) begin
                out_if.out_valid <= 1'b1;
                out_if.out_data  <= buffer[rd_ptr[IDX_W-1:0]];
                out_if.out_index <= rd_ptr[IDX_W-1:0];
                out_if.out_last  <= (rd_ptr == ring_r - PTR_ONE);
                rd_ptr           <= rd_ptr + PTR_ONE;
            end else if (xfer) begin
                out_if.out_valid <= 1'b0;
                out_if.out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CAPTURE) begin
            buffer[wr_addr_full[IDX_W-1:0]] <= c_red;
        end
    end

`ifdef RESULT_RANGE_CHECK_EN
    logic word_over;
    // With upper bits clear, dout0 equals c, so comparing c against 2q covers the full word.
    assign word_over = (|dout0[DATA_W-1:COEF_W+1]) || (c >= {q_r, 1'b0});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            range_err <= 1'b0;
        end else if (state_q == IDLE && done_rise) begin
            range_err <= 1'b0;
        end else if (state_q == CAPTURE && word_over) begin
            range_err <= 1'b1;
        end
    end
`else
    assign range_err = 1'b0;
`endif
endmodule

// File: doc/ntt_result_collector.md
# ntt_result_collector

Downstream capture stage for the NTT core's `dout0`/`done` output stream. Once `done` rises, it collects the interleaved coefficient words, applies the final conditional subtraction to bring each value into [0, q), and writes them into a natural-order buffer. It then drains the polynomial over a valid/ready stream, which frees the core and host bench from reordering and reduction.

## Interface
Parameters:
- `DATA_W`, 32: width of `dout0` words from the NTT core.
- `COEF_W`, 12: stored/output coefficient width.
- `MAX_N`, 256: buffer depth (max ring size).
- `PE_DEPTH`, 3: log2 of PE count in the core. Burst length `BURST = 1 << (PE_DEPTH+1)`.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: reset, asynchronous and active-low.
- `done`, in, 1: NTT core completion flag.
- `dout0`, in, DATA_W: NTT core output word.
- `q`, in, COEF_W: modulus, sampled at the `done` rising edge.
- `ring_size`, in, 12: polynomial length, sampled at the `done` rising edge.
- `out_valid`, out, 1: coefficient available.
- `out_ready`, in, 1: consumer accepts.
- `out_data`, out, COEF_W: reduced coefficient.
- `out_index`, out, log2(MAX_N): natural-order index of `out_data`.
- `out_last`, out, 1: asserted with index `ring_size-1`.
- `busy`, out, 1: high in any state other than IDLE.
- `range_err`, out, 1: sticky range error. See Configuration.

## Operation
- States: IDLE → ARM → CAPTURE ⇄ GAP → DRAIN → IDLE.
- IDLE: wait for a `done` rising edge (0 on the previous sample, 1 now). Latch `q` and `ring_size`. Clear the word counter `m`, `range_err`, and the drain pointer.
- ARM: one cycle. Input is ignored.
- CAPTURE: sample `dout0` every cycle for BURST cycles. Word `m` is written to a buffer address chosen by its parity:
  - even `m`: address `m>>1`.
  - odd `m`: address `(m>>1) + ring_size/2`.
- Reduction: `c = dout0[COEF_W:0]`. If `c >= q`, store `c - q`; otherwise store `c`. Only one subtraction is applied. Bits above COEF_W are ignored.
- GAP: one cycle after each burst, with input ignored. Then return to CAPTURE, or go to DRAIN when `m == ring_size`.
- DRAIN: present buffer entries at index 0 … ring_size-1 in order. The pointer advances only on `out_valid && out_ready`. After the transfer that carries `out_last`, return to IDLE.
- A `done` edge in any state other than IDLE is ignored.
- Legal `ring_size`: a power of two with 2·BURST ≤ ring_size ≤ MAX_N. Other values are undefined.
- Reset asserted at any time: state goes to IDLE and all counters clear. The buffer contents are not cleared.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_index` = 0, `out_last` = 0, `busy` = 0, `range_err` = 0.
- Let `done` first be sampled high at edge k:
  - ARM occupies edge k+1.
  - Word 0 is captured at edge k+2.
  - Burst j starts at edge k+2+j·(BURST+1).
- The final word is captured at edge L. `out_valid` rises after edge L+2, because the buffer read is registered.
- While `out_valid && !out_ready`, `out_data`, `out_index` and `out_last` hold stable.
- Full throughput: with `out_ready` held at 1, one coefficient transfers per cycle with no bubbles.
- `busy` rises after edge k. It falls after the edge that accepts `out_last`.

## Configuration
- `RESULT_RANGE_CHECK_EN` defined: during CAPTURE, a word is out of range if `dout0 >= 2·q` or any bit of `dout0` above COEF_W is set. An out-of-range word sets `range_err`, which stays high until the next accepted `done` edge or reset. The stored value still follows the single-subtract rule.
- Not defined: `range_err` is tied to 0 and no comparator logic is built.

## Test plan
- Ordering: PE_DEPTH=3, ring_size=256, q=3329, `dout0` = m during capture (zero in gaps). Required drain: index i<128 → 2i; index i≥128 → 2(i-128)+1. `out_last` only at index 255.
- Reduction: words 3328, 3329, 3330 and 6657. Required stored values: 3328, 0, 1, 3328.
- Backpressure: toggle `out_ready` pseudo-randomly. Required: all 256 values in order, none dropped or duplicated, and outputs stable while stalled.
- Reset mid-capture: assert `reset` low at burst 5. Required: all outputs go to 0 immediately. A subsequent `done` edge yields a correct full capture.
- Small ring: ring_size=64, with a second `done` pulse during DRAIN. Required: 64 outputs, then return to IDLE, and the second pulse is ignored.
- Range check: with `RESULT_RANGE_CHECK_EN`, one word 0x1A02 (≥2q) → `range_err` = 1 until the next `done` edge. Without the macro → `range_err` = 0.
